// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage with a DEPTH-entry prefetch queue, in-order variable-latency memory port
// and branch flush. Define IF_PREFETCH_BYPASS_EN to forward a response straight to ID when the queue is empty.
module if_prefetch_stage #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [INSTR_W-1:0] out_instr
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [ADDR_W-1:0]  fetch_pc;
  logic [CW-1:0]      count, outstanding, drop;
  logic [PW-1:0]      rd_ptr, wr_ptr, tag_rd, tag_wr;
  logic [ADDR_W-1:0]  fifo_pc    [DEPTH];
  logic [INSTR_W-1:0] fifo_instr [DEPTH];
  logic [ADDR_W-1:0]  tag_pc     [DEPTH];

  logic [CW:0] inflight;
  logic        accept, resp_keep, head_valid, push, pop;

  assign inflight   = {1'b0, count} + {1'b0, outstanding};
  // Gating with reset keeps the request low for the whole time reset is held.
  assign imem_req   = reset && !branch_taken && (inflight < DEPTH_W);
  assign imem_addr  = fetch_pc;
  assign accept     = imem_req && imem_gnt;
  assign resp_keep  = imem_rvalid && (drop == '0) && !branch_taken;
  assign head_valid = (count != '0);
  assign pop        = head_valid && out_ready && !branch_taken;

`ifdef IF_PREFETCH_BYPASS_EN
  logic bypass;
  assign bypass    = resp_keep && (count == '0);
  assign out_valid = head_valid || bypass;
  assign out_pc    = head_valid ? fifo_pc[rd_ptr]    : (bypass ? tag_pc[tag_rd] : '0);
  assign out_instr = head_valid ? fifo_instr[rd_ptr] : (bypass ? imem_rdata     : '0);
  assign push      = resp_keep && !(bypass && out_ready);
`else
  assign out_valid = head_valid;
  assign out_pc    = head_valid ? fifo_pc[rd_ptr]    : '0;
  assign out_instr = head_valid ? fifo_instr[rd_ptr] : '0;
  assign push      = resp_keep;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      tag_rd      <= '0;
      tag_wr      <= '0;
    end else if (branch_taken) begin
      fetch_pc    <= branch_addr;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      tag_rd      <= '0;
      tag_wr      <= '0;
      outstanding <= outstanding - CW'(imem_rvalid);
      // outstanding already covers responses still marked for dropping, so every
      // request in flight after this cycle belongs to the abandoned stream.
      drop        <= outstanding - CW'(imem_rvalid);
    end else begin
      if (accept) begin
        fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
        tag_wr   <= tag_wr + 1'b1;
      end
      outstanding <= outstanding + CW'(accept) - CW'(imem_rvalid);
      if (imem_rvalid && (drop != '0)) drop <= drop - 1'b1;
      if (resp_keep) tag_rd <= tag_rd + 1'b1;
      if (push)      wr_ptr <= wr_ptr + 1'b1;
      if (pop)       rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage arrays carry no reset; validity is tracked by the counters above.
  always_ff @(posedge clk) begin
    if (accept) tag_pc[tag_wr] <= fetch_pc;
    if (push && !branch_taken) begin
      fifo_pc[wr_ptr]    <= tag_pc[tag_rd];
      fifo_instr[wr_ptr] <= imem_rdata;
    end
  end

  a_rvalid_with_outstanding: assert property (
    @(posedge clk) disable iff (!reset) imem_rvalid |-> (outstanding != '0));

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Self-checking bench for if_prefetch_stage: startup vector table, scoreboard on the ID port,
// and directed sequences for stall, flush, grant stall, PC wrap and asynchronous reset.
module tb_if_prefetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0;
`ifdef IF_PREFETCH_BYPASS_EN
  localparam int OUT_LAT = 1;
`else
  localparam int OUT_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  if_prefetch_stage #(
    .ADDR_W(32), .INSTR_W(32), .DEPTH(4), .RESET_PC(RESET_PC), .PC_STEP(4)
  ) dut (
    .clk(clk), .reset(reset), .branch_taken(branch_taken), .branch_addr(branch_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [31:0] addr; } mem_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  typedef struct {
    bit gnt; bit ready; bit e_req; logic [31:0] e_addr; bit e_valid; logic [31:0] e_pc;
  } vec_t;

  mem_t pend[$];
  exp_t exp_q[$];
  int   n_vec = 0, n_err = 0;
  int   cyc = 0, lat = 1;
  logic [31:0] model_pc = RESET_PC;

  logic        s_req, s_valid, s_acc, s_pop, s_rv, s_br;
  logic [31:0] s_addr, s_pc, s_instr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end else
      $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
  endtask

  task automatic drive_mem();
    if (pend.size() > 0 && pend[0].due == cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = ~pend[0].addr;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
  endtask

  // One clock cycle: sample and score at the falling edge, advance the memory model after the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    s_req = imem_req;  s_addr = imem_addr;  s_valid = out_valid;
    s_pc = out_pc;     s_instr = out_instr;
    s_acc = imem_req && imem_gnt;
    s_pop = out_valid && out_ready && !branch_taken;
    s_rv = imem_rvalid; s_br = branch_taken;
    if (s_acc) begin
      chk("req_addr", s_addr, model_pc);
      exp_q.push_back('{model_pc, ~model_pc});
      model_pc += 32'd4;
    end
    if (s_pop) begin
      if (exp_q.size() == 0) fail("pop_unexpected");
      else begin
        e = exp_q.pop_front();
        chk("sb_out_pc", s_pc, e.pc);
        chk("sb_out_instr", s_instr, e.instr);
      end
    end
    if (s_br) begin
      exp_q.delete();
      model_pc = branch_addr;
    end
    @(posedge clk);
    #1;
    if (s_rv) void'(pend.pop_front());
    if (s_acc) pend.push_back('{cyc + lat, s_addr});
    cyc++;
    drive_mem();
  endtask

  task automatic assert_reset();
    reset = 1'b0;
    branch_taken = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    pend.delete();
    exp_q.delete();
    model_pc = RESET_PC;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    cyc = 0;
    drive_mem();
  endtask

  task automatic wait_pop(input string name, input logic [31:0] exp_pc);
    bit got = 0;
    for (int t = 0; t < 30 && !got; t++) begin
      tick();
      if (s_pop) begin
        got = 1;
        chk(name, s_pc, exp_pc);
      end
    end
    if (!got) fail(name);
  endtask

  vec_t tbl[8];

  initial begin
    // startup vectors: gnt=1, k=1, ready=1
    for (int i = 0; i < 8; i++) begin
      tbl[i].gnt = 1; tbl[i].ready = 1; tbl[i].e_req = 1;
      tbl[i].e_addr = 32'(4 * i);
      tbl[i].e_valid = (i >= OUT_LAT);
      tbl[i].e_pc = (i >= OUT_LAT) ? 32'(4 * (i - OUT_LAT)) : 32'h0;
    end

    #2 assert_reset();
    #1;
    chk("rst_imem_req", imem_req, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_imem_addr", imem_addr, RESET_PC);

    lat = 1; imem_gnt = 1; out_ready = 1;
    release_reset();
    for (int i = 0; i < 8; i++) begin
      imem_gnt = tbl[i].gnt;
      out_ready = tbl[i].ready;
      tick();
      chk($sformatf("tbl%0d_req", i), s_req, tbl[i].e_req);
      chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_valid", i), s_valid, tbl[i].e_valid);
      if (tbl[i].e_valid) chk($sformatf("tbl%0d_pc", i), s_pc, tbl[i].e_pc);
    end

    // stall ID for 10 cycles from reset
    assert_reset();
    out_ready = 0; imem_gnt = 1; lat = 1;
    release_reset();
    begin
      int n_acc = 0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (s_acc) n_acc++;
      end
      chk("stall_accepts", n_acc, 4);
      chk("stall_req_low", s_req, 0);
    end
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("drain%0d_valid", i), s_valid, 1);
      chk($sformatf("drain%0d_pc", i), s_pc, 32'(4 * i));
      if (i < 2) chk($sformatf("drain%0d_req", i), s_req, (i == 1));
    end

    // flush with three requests in flight, none returning in the flush cycle
    assert_reset();
    out_ready = 1; imem_gnt = 1; lat = 4;
    release_reset();
    repeat (3) tick();
    imem_gnt = 0; branch_taken = 1; branch_addr = 32'h100;
    tick();
    branch_taken = 0; imem_gnt = 1;
    tick();
    chk("br_b1_valid", s_valid, 0);
    chk("br_b1_req", s_req, 1);
    chk("br_b1_addr", s_addr, 32'h100);
    wait_pop("br_first_pc", 32'h100);
    wait_pop("br_second_pc", 32'h104);

    // flush coinciding with a response and an ID acceptance
    assert_reset();
    out_ready = 1; imem_gnt = 1; lat = 2;
    release_reset();
    repeat (8) tick();
    branch_taken = 1; branch_addr = 32'h200;
    tick();
    chk("flushcyc_valid", s_valid, 1);
    chk("flushcyc_rvalid_seen", s_rv, 1);
    branch_taken = 0;
    tick();
    chk("flush_b1_valid", s_valid, 0);
    chk("flush_b1_addr", s_addr, 32'h200);
    wait_pop("flush_first_pc", 32'h200);

    // grant held low: address stable, no progress
    imem_gnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("nognt%0d_req", i), s_req, 1);
      chk($sformatf("nognt%0d_addr", i), s_addr, model_pc);
    end

    // PC wrap
    branch_taken = 1; branch_addr = 32'hFFFF_FFFC;
    tick();
    branch_taken = 0; imem_gnt = 1;
    tick();
    chk("wrap_addr0", s_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_addr1", s_addr, 32'h0);
    wait_pop("wrap_first_pc", 32'hFFFF_FFFC);
    repeat (6) tick();
    chk("pre_async_valid", out_valid, 1);

    // asynchronous reset between edges
    #2;
    assert_reset();
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_imem_req", imem_req, 0);
    chk("async_imem_addr", imem_addr, RESET_PC);
    lat = 1;
    release_reset();
    tick();
    chk("restart_req", s_req, 1);
    chk("restart_addr", s_addr, RESET_PC);
    wait_pop("restart_first_pc", RESET_PC);
    repeat (6) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
